result_digit_encoder: RTL and testbench

RESULT_DIGIT_ENCODER -- requirements
Module: result_digit_encoder

---
 rtl/result_digit_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_result_digit_encoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/result_digit_encoder.sv
// result_digit_encoder
// Converts a signed 8-bit result into four display character codes. A numeric
// result is converted with a shift-and-add-3 BCD loop. An error request shows
// "Err" instead.
// Ports:
//   clk, reset              - rising-edge clock, async active-high reset
//   start                   - conversion request, sampled only when idle
//   result[7:0], errorFlag  - operands captured on an accepted start
//   char3..char0[4:0]       - character codes, char3 leftmost
//   enable3..enable0        - per-digit display enables
//   busy                    - conversion in progress
//   done                    - one-cycle pulse when new outputs are valid
module result_digit_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] result,
  input  logic       errorFlag,
  output logic [4:0] char3,
  output logic [4:0] char2,
  output logic [4:0] char1,
  output logic [4:0] char0,
  output logic       enable3,
  output logic       enable2,
  output logic       enable1,
  output logic       enable0,
  output logic       busy,
  output logic       done
);

  localparam int unsigned RES_W  = 8;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned CHAR_W = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ITER   = 8;

  localparam logic [CHAR_W-1:0] CH_MINUS = 5'd11;
  localparam logic [CHAR_W-1:0] CH_R     = 5'd13;
  localparam logic [CHAR_W-1:0] CH_E     = 5'd14;
  localparam logic [CHAR_W-1:0] CH_BLANK = 5'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FORMAT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [RES_W-1:0]    mag_q, mag_d;
  logic                neg_q, neg_d;
  logic                err_q, err_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHAR_W-1:0]   char3_q, char3_d, char2_q, char2_d;
  logic [CHAR_W-1:0]   char1_q, char1_d, char0_q, char0_d;
  logic                en3_q, en3_d, en2_q, en2_d, en1_q, en1_d, en0_q, en0_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [BCD_W-1:0]    bcd_adj;
  logic [3:0]          hund, tens, ones;
  logic                show_hund, show_tens;

  assign hund      = bcd_q[11:8];
  assign tens      = bcd_q[7:4];
  assign ones      = bcd_q[3:0];
  assign show_hund = (hund != 4'd0);
  assign show_tens = show_hund || (tens != 4'd0);

  // Add 3 to each BCD nibble >= 5 so the following shift carries correctly.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    err_d   = err_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    char3_d = char3_q;
    char2_d = char2_q;
    char1_d = char1_q;
    char0_d = char0_q;
    en3_d   = en3_q;
    en2_d   = en2_q;
    en1_d   = en1_q;
    en0_d   = en0_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Two's-complement negate; 8'h80 maps to 128 unsigned.
          mag_d   = result[7] ? RES_W'(~result + 8'd1) : result;
          neg_d   = result[7];
          err_d   = errorFlag;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = errorFlag ? FORMAT : SHIFT;
        end
      end

      SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = FORMAT;
        end
      end

      FORMAT: begin
        if (err_q) begin
          char3_d = CH_BLANK;  en3_d = 1'b0;
          char2_d = CH_E;      en2_d = 1'b1;
          char1_d = CH_R;      en1_d = 1'b1;
          char0_d = CH_R;      en0_d = 1'b1;
        end else begin
          // Zero always has neg_q=0, so '-' never appears for zero.
          char3_d = neg_q ? CH_MINUS : CH_BLANK;
          en3_d   = neg_q;
          char2_d = show_hund ? CHAR_W'(hund) : CH_BLANK;
          en2_d   = show_hund;
          char1_d = show_tens ? CHAR_W'(tens) : CH_BLANK;
          en1_d   = show_tens;
          char0_d = CHAR_W'(ones);
          en0_d   = 1'b1;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      char3_q <= CH_BLANK;
      char2_q <= CH_BLANK;
      char1_q <= CH_BLANK;
      char0_q <= CH_BLANK;
      en3_q   <= 1'b0;
      en2_q   <= 1'b0;
      en1_q   <= 1'b0;
      en0_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      char3_q <= char3_d;
      char2_q <= char2_d;
      char1_q <= char1_d;
      char0_q <= char0_d;
      en3_q   <= en3_d;
      en2_q   <= en2_d;
      en1_q   <= en1_d;
      en0_q   <= en0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign char3   = char3_q;
  assign char2   = char2_q;
  assign char1   = char1_q;
  assign char0   = char0_q;
  assign enable3 = en3_q;
  assign enable2 = en2_q;
  assign enable1 = en1_q;
  assign enable0 = en0_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_result_digit_encoder.sv
// Self-checking bench for result_digit_encoder: directed cases with literal
// expectations plus randomized traffic compared each cycle to a reference model.
module tb_result_digit_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] result = 8'd0;
  logic       errorFlag = 1'b0;
  logic [4:0] char3, char2, char1, char0;
  logic       enable3, enable2, enable1, enable0;
  logic       busy, done;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  result_digit_encoder dut (
    .clk(clk), .reset(reset), .start(start), .result(result), .errorFlag(errorFlag),
    .char3(char3), .char2(char2), .char1(char1), .char0(char0),
    .enable3(enable3), .enable2(enable2), .enable1(enable1), .enable0(enable0),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Display expected for a value, from plain decimal arithmetic: {chars[19:0], en[3:0]}.
  function automatic logic [23:0] exp_disp(input logic [7:0] r, input bit e);
    int v, m, h, t, o;
    logic [4:0] c3, c2, c1, c0;
    logic [3:0] en;
    if (e) return {5'd15, 5'd14, 5'd13, 5'd13, 4'b0111};
    v = int'($signed(r));
    m = (v < 0) ? -v : v;
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    c3 = (v < 0) ? 5'd11 : 5'd15;
    c2 = (m >= 100) ? 5'(h) : 5'd15;
    c1 = (m >= 10) ? 5'(t) : 5'd15;
    c0 = 5'(o);
    en = {v < 0, m >= 100, m >= 10, 1'b1};
    return {c3, c2, c1, c0, en};
  endfunction

  // Reference model: a conversion takes 9 cycles (1 for error) from acceptance.
  bit         m_busy, m_done;
  logic [19:0] m_chars;
  logic [3:0]  m_en;
  int          m_rem;
  logic [7:0]  m_res;
  bit          m_err;
  logic [23:0] m_tmp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
      m_chars = {4{5'd15}}; m_en = 4'b0000;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1; m_res = result; m_err = errorFlag;
          m_rem = errorFlag ? 1 : 9;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_tmp = exp_disp(m_res, m_err);
          m_chars = m_tmp[23:4]; m_en = m_tmp[3:0];
          m_done = 1'b1; m_busy = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (chk_on)
      chk("cycle_outputs",
          {busy, done, char3, char2, char1, char0, enable3, enable2, enable1, enable0},
          {m_busy, m_done, m_chars, m_en});
  end

  // Directed conversion with literal expectations; called at a negedge while idle.
  task automatic run_conv(input logic [7:0] r, input bit e, input int extra_at,
                          input logic [19:0] xc, input logic [3:0] xe, input int xlat);
    int lat, ndone;
    lat = 0;
    result = r; errorFlag = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    result = 8'($urandom); errorFlag = 1'($urandom);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      start = (lat == extra_at);
    end
    start = 1'b0;
    chk("latency", lat, xlat);
    chk("chars", {char3, char2, char1, char0}, xc);
    chk("enables", {enable3, enable2, enable1, enable0}, xe);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_extra_done", ndone, 0);
    chk("hold_chars", {char3, char2, char1, char0}, xc);
  endtask

  initial begin
    logic [23:0] pin;
    pin = exp_disp(8'h80, 1'b0);
    chk("model_pin_m128", pin, {5'd11, 5'd1, 5'd2, 5'd8, 4'b1111});
    pin = exp_disp(8'd0, 1'b0);
    chk("model_pin_zero", pin, {5'd15, 5'd15, 5'd15, 5'd0, 4'b0001});

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_state", {busy, done, char3, char2, char1, char0, enable3, enable2, enable1, enable0},
        {2'b00, {4{5'd15}}, 4'b0000});
    chk_on = 1'b1;

    run_conv(8'd123, 1'b0, 0, {5'd15, 5'd1, 5'd2, 5'd3}, 4'b0111, 9);
    run_conv(8'h80,  1'b0, 0, {5'd11, 5'd1, 5'd2, 5'd8}, 4'b1111, 9);
    run_conv(8'hF9,  1'b0, 0, {5'd11, 5'd15, 5'd15, 5'd7}, 4'b1001, 9);
    run_conv(8'd0,   1'b0, 0, {5'd15, 5'd15, 5'd15, 5'd0}, 4'b0001, 9);
    run_conv(8'd55,  1'b1, 0, {5'd15, 5'd14, 5'd13, 5'd13}, 4'b0111, 1);
    run_conv(8'd99,  1'b0, 4, {5'd15, 5'd15, 5'd9, 5'd9}, 4'b0011, 9);

    // Reset in the middle of SHIFT, then an immediate start after release.
    result = 8'd99; errorFlag = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("reset_mid_shift",
           {busy, done, char3, char2, char1, char0, enable3, enable2, enable1, enable0},
           {2'b00, {4{5'd15}}, 4'b0000});
    @(negedge clk);
    reset = 1'b0;
    run_conv(8'd42, 1'b0, 0, {5'd15, 5'd15, 5'd4, 5'd2}, 4'b0011, 9);

    // Randomized traffic, including held start and occasional async resets.
    begin
      bit hold;
      logic [7:0] corner [8];
      corner = '{8'd0, 8'd127, 8'h80, 8'hFF, 8'd99, 8'd100, 8'd9, 8'd10};
      hold = 1'b0;
      repeat (600) begin
        @(negedge clk);
        if ($urandom_range(0, 19) == 0) hold = ~hold;
        start = hold || ($urandom_range(0, 3) == 0);
        result = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 7)] : 8'($urandom);
        errorFlag = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 150) == 0) begin
          #2 reset = 1'b1;
          #1 reset = 1'b0;
        end
      end
      start = 1'b0;
      repeat (15) @(negedge clk);
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
